// File: rtl/alu_seq_exec.sv
// Multi-cycle RV32I execute unit: one-cycle logic/arithmetic, iterative shifter, valid/ready in and out.
// Define ALU_SEQ_FAST_SHIFT_EN to shift up to 4 bits per cycle instead of 1.
module alu_seq_exec #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_ALUControlLines,
  input  logic [DATA_WIDTH-1:0] i_A,
  input  logic [DATA_WIDTH-1:0] i_B,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_illegal
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [1:0]            state, state_next;
  logic [SHAMT_W-1:0]    count, count_next;
  logic [DATA_WIDTH-1:0] work, work_next;
  logic [3:0]            op, op_next;
  logic [DATA_WIDTH-1:0] result_next;
  logic                  zero_next, illegal_next;

  logic [SHAMT_W-1:0]    shamt_c, step_c;
  logic [DATA_WIDTH-1:0] alu_c, shifted_c;
  logic                  illegal_c, is_shift_c;

  // Single-cycle datapath on the live request operands
  always_comb begin
    shamt_c    = i_B[SHAMT_W-1:0];
    illegal_c  = 1'b0;
    is_shift_c = (i_ALUControlLines == OP_SLL) || (i_ALUControlLines == OP_SRL) ||
                 (i_ALUControlLines == OP_SRA);
    case (i_ALUControlLines)
      OP_AND:  alu_c = i_A & i_B;
      OP_OR:   alu_c = i_A | i_B;
      OP_ADD:  alu_c = i_A + i_B;
      OP_XOR:  alu_c = i_A ^ i_B;
      OP_SLL:  alu_c = i_A << shamt_c;
      OP_SRL:  alu_c = i_A >> shamt_c;
      OP_SUB:  alu_c = i_A - i_B;
      OP_SRA:  alu_c = DATA_WIDTH'($signed(i_A) >>> shamt_c);
      OP_SLT:  alu_c = DATA_WIDTH'($signed(i_A) < $signed(i_B));
      OP_SLTU: alu_c = DATA_WIDTH'(i_A < i_B);
      default: begin
        alu_c     = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Iterative shifter step on the captured working register
  always_comb begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
    step_c = (count < SHAMT_W'(4)) ? count : SHAMT_W'(4);
`else
    step_c = SHAMT_W'(1);
`endif
    case (op)
      OP_SLL:  shifted_c = work << step_c;
      OP_SRA:  shifted_c = DATA_WIDTH'($signed(work) >>> step_c);
      default: shifted_c = work >> step_c;
    endcase
  end

  // Next-state and result-load logic
  always_comb begin
    state_next   = state;
    count_next   = count;
    work_next    = work;
    op_next      = op;
    result_next  = o_result;
    zero_next    = o_zero;
    illegal_next = o_illegal;
    case (state)
      IDLE: begin
        if (i_valid) begin
          op_next = i_ALUControlLines;
          if (is_shift_c && (shamt_c != '0)) begin
            work_next  = i_A;
            count_next = shamt_c;
            state_next = SHIFT;
          end else begin
            result_next  = alu_c;
            zero_next    = (alu_c == '0);
            illegal_next = illegal_c;
            state_next   = DONE;
          end
        end
      end
      SHIFT: begin
        work_next  = shifted_c;
        count_next = count - step_c;
        if (count == step_c) begin
          result_next  = shifted_c;
          zero_next    = (shifted_c == '0);
          illegal_next = 1'b0;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      count     <= '0;
      work      <= '0;
      op        <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_zero    <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      work      <= work_next;
      op        <= op_next;
      o_ready   <= (state_next == IDLE);
      o_valid   <= (state_next == DONE);
      o_result  <= result_next;
      o_zero    <= zero_next;
      o_illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec; expected values are hand-computed.
// Latency expectations follow ALU_SEQ_FAST_SHIFT_EN when it is defined.
module tb_alu_seq_exec;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_ALUControlLines = 4'h0;
  logic [31:0] i_A = '0;
  logic [31:0] i_B = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_illegal;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [31:0] held;

  always #5 i_clk = ~i_clk;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ALUControlLines(i_ALUControlLines), .i_A(i_A), .i_B(i_B),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_illegal(o_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int shift_lat(input int k);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1 + (k + 3) / 4;
`else
    return 1 + k;
`endif
  endfunction

  // Issue one request, scramble inputs after acceptance, return cycles until o_valid
  task automatic do_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    @(negedge i_clk);
    check("ready_at_issue", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_ALUControlLines = ctl;
    i_A = a;
    i_B = b;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ALUControlLines = 4'h2;
    i_A = 32'hDEAD_BEEF;
    i_B = 32'h0000_001F;
    cycles = 1;
    while (o_valid !== 1'b1 && cycles < 100) begin
      @(negedge i_clk);
      cycles++;
    end
  endtask

  task automatic retire(input logic [31:0] exp_res);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("ready_after_retire", 32'(o_ready), 32'd1);
    check("valid_after_retire", 32'(o_valid), 32'd0);
    check("result_held_after_retire", o_result, exp_res);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_zero", 32'(o_zero), 32'd0);
    check("rst_illegal", 32'(o_illegal), 32'd0);

    do_op(4'b0010, 32'd5, 32'd7, lat);
    check("add_lat", 32'(lat), 32'd1);
    check("add_result", o_result, 32'd12);
    check("add_zero", 32'(o_zero), 32'd0);
    check("add_illegal", 32'(o_illegal), 32'd0);
    retire(32'd12);

    do_op(4'b0110, 32'd3, 32'd3, lat);
    check("sub_lat", 32'(lat), 32'd1);
    check("sub_result", o_result, 32'd0);
    check("sub_zero", 32'(o_zero), 32'd1);
    retire(32'd0);

    do_op(4'b0111, 32'h8000_0000, 32'd4, lat);
    check("sra_lat", 32'(lat), 32'(shift_lat(4)));
    check("sra_result", o_result, 32'hF800_0000);
    check("sra_zero", 32'(o_zero), 32'd0);
    retire(32'hF800_0000);

    do_op(4'b0100, 32'd1, 32'h0000_0025, lat);
    check("sll_lat", 32'(lat), 32'(shift_lat(5)));
    check("sll_result", o_result, 32'h0000_0020);
    retire(32'h0000_0020);

    // Shift amount masks to zero: completes like a one-cycle op
    do_op(4'b0101, 32'h0000_1234, 32'h0000_0020, lat);
    check("srl0_lat", 32'(lat), 32'd1);
    check("srl0_result", o_result, 32'h0000_1234);
    retire(32'h0000_1234);

    do_op(4'b1000, 32'hFFFF_FFFF, 32'd1, lat);
    check("slt_lat", 32'(lat), 32'd1);
    check("slt_result", o_result, 32'd1);
    retire(32'd1);

    do_op(4'b1001, 32'hFFFF_FFFF, 32'd1, lat);
    check("sltu_result", o_result, 32'd0);
    check("sltu_zero", 32'(o_zero), 32'd1);
    retire(32'd0);

    do_op(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
    check("xor_lat", 32'(lat), 32'd1);
    check("xor_result", o_result, 32'h0F0F_F0F0);

    // Backpressure with a competing request that must be ignored
    i_valid = 1'b1;
    i_ALUControlLines = 4'b0010;
    i_A = 32'd1;
    i_B = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_result", o_result, 32'h0F0F_F0F0);
      check("bp_ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    retire(32'h0F0F_F0F0);
    @(negedge i_clk);
    check("bp_ignored_valid", 32'(o_valid), 32'd0);
    check("bp_ignored_result", o_result, 32'h0F0F_F0F0);

    do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_result", o_result, 32'd0);
    check("ill_illegal", 32'(o_illegal), 32'd1);
    check("ill_zero", 32'(o_zero), 32'd1);
    retire(32'd0);

    // Reset during a long SRL drops the operation
    @(negedge i_clk);
    i_valid = 1'b1;
    i_ALUControlLines = 4'b0101;
    i_A = 32'hFFFF_FFFF;
    i_B = 32'd20;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("srl_in_shift_valid", 32'(o_valid), 32'd0);
    check("srl_in_shift_ready", 32'(o_ready), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_result", o_result, 32'd0);
    check("midrst_zero", 32'(o_zero), 32'd0);
    check("midrst_illegal", 32'(o_illegal), 32'd0);

    do_op(4'b0010, 32'd1, 32'd1, lat);
    check("post_rst_add_lat", 32'(lat), 32'd1);
    check("post_rst_add_result", o_result, 32'd2);
    held = o_result;
    retire(held);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
